// File: rtl/neuron_lif_array.sv
// Array of leaky integrate-and-fire neurons with a sequential tick sweep and spike FIFO.
// Optional refractory counters are enabled by defining NEURON_LIF_ARRAY_REFRAC_EN.
module neuron_lif_array #(
  parameter int N_NEURONS    = 8,
  parameter int V_W          = 8,
  parameter int WGT_W        = 4,
  parameter int LEAK_SHIFT   = 3,
  parameter int THRESH_INIT  = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int REFRAC_TICKS = 2,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_tick,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [WGT_W-1:0] in_weight,
  input  logic             cfg_we,
  input  logic [V_W-1:0]   cfg_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             err
);

  localparam int FA_W = $clog2(FIFO_DEPTH);
  localparam int CN_W = FA_W + 1;
  localparam int S_W  = V_W + 2;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [V_W-1:0]   v_q [N_NEURONS];
  logic [V_W-1:0]   v_d [N_NEURONS];
  logic [V_W-1:0]   thresh_q;
  logic             err_q;
  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [FA_W-1:0]  wr_q, rd_q;
  logic [CN_W-1:0]  cnt_q;

  logic             accept, idx_ok, ev_ok;
  logic [V_W-1:0]   ev_cur, ev_new;
  logic [S_W-1:0]   sum;
  logic [V_W-1:0]   sw_cur, vl;
  logic             sweeping, spike, full, pop, push, stall, adv;
  logic             ev_hold, sw_hold;

  assign in_ready  = rst_n & ena & (state_q == IDLE);
  assign busy      = (state_q == SWEEP);
  assign err       = err_q;
  assign out_valid = (cnt_q != '0);
  assign out_idx   = fifo_q[rd_q];

  assign accept = in_valid & in_ready;
  assign idx_ok = int'(in_idx) < N_NEURONS;
  assign ev_ok  = accept & ~in_tick & idx_ok & ~ev_hold;

  always_comb begin
    ev_cur = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (in_idx == IDX_W'(i)) ev_cur = v_q[i];
    end
  end

  // Signed add in V_W+2 bits so both underflow and overflow are visible.
  assign sum = {2'b00, ev_cur}
             + {{(S_W-WGT_W){in_weight[WGT_W-1]}}, in_weight};

  always_comb begin
    ev_new = sum[V_W-1:0];
    if (sum[S_W-1])    ev_new = '0;
    else if (sum[V_W]) ev_new = '1;
  end

  assign sweeping = (state_q == SWEEP);
  assign sw_cur   = v_q[ptr_q];
  assign vl       = sw_cur - (sw_cur >> LEAK_SHIFT);
  assign spike    = sweeping & ~sw_hold & (vl >= thresh_q);
  assign full     = (cnt_q == CN_W'(FIFO_DEPTH));
  assign pop      = out_valid & out_ready & ena;
  assign stall    = spike & full & ~pop;
  assign push     = ena & spike & ~stall;
  assign adv      = ena & sweeping & ~stall;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (ev_ok && in_idx == IDX_W'(i)) v_d[i] = ev_new;
      if (adv && !sw_hold && ptr_q == IDX_W'(i))
        v_d[i] = spike ? '0 : vl;
    end
  end

`ifdef NEURON_LIF_ARRAY_REFRAC_EN
  localparam int RC_W = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;

  logic [RC_W-1:0] rc_q [N_NEURONS];
  logic [RC_W-1:0] rc_d [N_NEURONS];

  always_comb begin
    ev_hold = 1'b0;
    sw_hold = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (in_idx == IDX_W'(i) && rc_q[i] != '0) ev_hold = 1'b1;
      if (ptr_q == IDX_W'(i) && rc_q[i] != '0) sw_hold = 1'b1;
    end
  end

  always_comb begin
    rc_d = rc_q;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (adv && ptr_q == IDX_W'(i)) begin
        if (rc_q[i] != '0) rc_d[i] = rc_q[i] - 1'b1;
        else if (spike)    rc_d[i] = RC_W'(REFRAC_TICKS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) rc_q[i] <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end
`else
  assign ev_hold = 1'b0;
  assign sw_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && in_tick) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          if (adv) begin
            if (ptr_q == IDX_W'(N_NEURONS - 1)) state_q <= IDLE;
            else                                ptr_q   <= ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= '0;
      thresh_q <= V_W'(THRESH_INIT);
      err_q    <= 1'b0;
    end else begin
      v_q <= v_d;
      if (ena && cfg_we) thresh_q <= cfg_thresh;
      if (accept && !in_tick && !idx_ok) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= ptr_q;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_lif_array.sv
// Scoreboard bench for neuron_lif_array: a behavioural membrane model
// predicts spike indices, which are compared as the FIFO drains.
module tb_neuron_lif_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_valid6 = 1'b0;
  logic       in_tick = 1'b0;
  logic [2:0] in_idx = '0;
  logic [3:0] in_weight = '0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_thresh = '0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, busy, err;
  logic [2:0] out_idx;
  logic       in_ready6, out_valid6, busy6, err6;
  logic [2:0] out_idx6;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  logic [2:0] sb[$];
  int mv[8];
  int mrc[8];
  int mthr = 64;

  always #5 clk = ~clk;

  neuron_lif_array dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_tick(in_tick),
    .in_idx(in_idx), .in_weight(in_weight),
    .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .busy(busy), .err(err)
  );

  neuron_lif_array #(.N_NEURONS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_tick(in_tick),
    .in_idx(in_idx), .in_weight(in_weight),
    .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .out_valid(out_valid6), .out_ready(1'b1), .out_idx(out_idx6),
    .busy(busy6), .err(err6)
  );

  // One clock: scoreboard check at negedge, then return at posedge+1.
  task automatic step();
    logic [2:0] e;
    @(negedge clk);
    if (rst_n && ena && out_valid && out_ready) begin
      vectors++;
      pops++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spike_pop: got idx %0d, required no spike", out_idx);
      end else begin
        e = sb.pop_front();
        if (out_idx !== e) begin
          miscompares++;
          $display("FAIL spike_pop: got idx %0d, required %0d", out_idx, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_ev(input int idx, input logic [3:0] w);
    int s;
    if (mrc[idx] == 0) begin
      s = mv[idx] + int'($signed(w));
      mv[idx] = (s < 0) ? 0 : (s > 255) ? 255 : s;
    end
  endtask

  task automatic model_tick();
    int vl;
    for (int i = 0; i < 8; i++) begin
      if (mrc[i] != 0) begin
        mrc[i]--;
      end else begin
        vl = mv[i] - (mv[i] >> 3);
        if (vl >= mthr) begin
          sb.push_back(3'(i));
          mv[i] = 0;
`ifdef NEURON_LIF_ARRAY_REFRAC_EN
          mrc[i] = 2;
`endif
        end else begin
          mv[i] = vl;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 300) begin
      step();
      t++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_wait: in_ready %b after %0d cycles, required 1", in_ready, t);
    end
  endtask

  task automatic send(input logic [2:0] idx, input logic [3:0] w, input int n);
    wait_idle();
    in_valid = 1'b1;
    in_tick = 1'b0;
    in_idx = idx;
    in_weight = w;
    for (int k = 0; k < n; k++) begin
      step();
      model_ev(int'(idx), w);
    end
    in_valid = 1'b0;
  endtask

  task automatic tick();
    wait_idle();
    in_valid = 1'b1;
    in_tick = 1'b1;
    step();
    in_valid = 1'b0;
    in_tick = 1'b0;
    model_tick();
  endtask

  task automatic cfg(input logic [7:0] t);
    wait_idle();
    cfg_we = 1'b1;
    cfg_thresh = t;
    step();
    cfg_we = 1'b0;
    mthr = int'(t);
  endtask

  task automatic finish_sweep();
    int t = 0;
    while (busy && t < 300) begin
      step();
      t++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_end: busy %b after %0d cycles, required 0", busy, t);
    end
    repeat (6) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d spikes missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic charge(input logic [2:0] idx);
    send(idx, 4'd7, 28);
    send(idx, 4'd4, 1);
  endtask

  task automatic test_reset();
    #1;
    vectors += 5;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_in_ready: got %b, required 0", in_ready);
    end
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_busy: got %b, required 0", busy);
    end
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL rst_err: got %b, required 0", err);
    end
    if (out_idx !== 3'd0) begin
      miscompares++; $display("FAIL rst_out_idx: got %0d, required 0", out_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tick_timing();
    tick();
    vectors += 3;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_start: busy %b in_ready %b, required 1 0", busy, in_ready);
    end
    repeat (7) step();
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL tick_last_slot: busy %b, required 1", busy);
    end
    step();
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_done: busy %b in_ready %b, required 0 1", busy, in_ready);
    end
    finish_sweep();
  endtask

  task automatic test_integrate();
    int base = pops;
    send(3'd3, 4'd7, 10);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 0) begin
      miscompares++; $display("FAIL leak_70: got %0d spikes, required 0", pops - base);
    end
    send(3'd3, 4'd7, 2);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 1) begin
      miscompares++; $display("FAIL spike_76: got %0d spikes, required 1", pops - base);
    end
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 1) begin
      miscompares++; $display("FAIL reset_v3: got %0d spikes, required 1", pops - base);
    end
  endtask

  task automatic test_clamp();
    int base = pops;
    cfg(8'd224);
    send(3'd0, 4'd7, 40);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 1) begin
      miscompares++; $display("FAIL clamp_hi: got %0d spikes, required 1", pops - base);
    end
    cfg(8'd64);
    send(3'd1, 4'd3, 1);
    send(3'd1, 4'h8, 1);
    send(3'd1, 4'd7, 10);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 1) begin
      miscompares++; $display("FAIL clamp_lo: got %0d spikes, required 1", pops - base);
    end
  endtask

  task automatic test_full_fifo();
    int base = pops;
    for (int i = 0; i < 8; i++) charge(3'(i));
    out_ready = 1'b0;
    tick();
    repeat (12) step();
    vectors += 4;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL stall_busy: got %b, required 1", busy);
    end
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL stall_ready: got %b, required 0", in_ready);
    end
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL stall_valid: got %b, required 1", out_valid);
    end
    if (out_idx !== 3'd0) begin
      miscompares++; $display("FAIL stall_head: got %0d, required 0", out_idx);
    end
    out_ready = 1'b1;
    finish_sweep();
    vectors++;
    if (pops - base != 8) begin
      miscompares++; $display("FAIL full_count: got %0d spikes, required 8", pops - base);
    end
  endtask

  task automatic test_ena();
    int base = pops;
    int t = 0;
    send(3'd5, 4'd7, 11);
    out_ready = 1'b0;
    tick();
    while (busy && t < 50) begin
      step();
      t++;
    end
    ena = 1'b0;
    out_ready = 1'b1;
    cfg_we = 1'b1;
    cfg_thresh = 8'd200;
    in_valid = 1'b1;
    in_idx = 3'd6;
    in_weight = 4'd7;
    repeat (4) step();
    vectors += 3;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      miscompares++;
      $display("FAIL ena_hold: valid %b idx %0d, required 1 5", out_valid, out_idx);
    end
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL ena_ready: got %b, required 0", in_ready);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL ena_busy: got %b, required 0", busy);
    end
    cfg_we = 1'b0;
    in_valid = 1'b0;
    ena = 1'b1;
    finish_sweep();
    send(3'd6, 4'd7, 11);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 2) begin
      miscompares++; $display("FAIL ena_count: got %0d spikes, required 2", pops - base);
    end
  endtask

  task automatic test_respike();
    int base = pops;
    send(3'd4, 4'd7, 11);
    tick();
    send(3'd4, 4'd7, 11);
    tick();
    finish_sweep();
    vectors++;
`ifdef NEURON_LIF_ARRAY_REFRAC_EN
    if (pops - base != 1) begin
      miscompares++; $display("FAIL respike: got %0d spikes, required 1", pops - base);
    end
`else
    if (pops - base != 2) begin
      miscompares++; $display("FAIL respike: got %0d spikes, required 2", pops - base);
    end
`endif
  endtask

  task automatic test_err();
    int t = 0;
    vectors++;
    if (err6 !== 1'b0) begin
      miscompares++; $display("FAIL err_init: got %b, required 0", err6);
    end
    in_valid6 = 1'b1;
    in_tick = 1'b0;
    in_idx = 3'd7;
    in_weight = 4'd7;
    step();
    vectors += 2;
    if (err6 !== 1'b1) begin
      miscompares++; $display("FAIL err_set: got %b, required 1", err6);
    end
    if (in_ready6 !== 1'b1) begin
      miscompares++; $display("FAIL err_ready: got %b, required 1", in_ready6);
    end
    repeat (10) step();
    in_tick = 1'b1;
    step();
    in_tick = 1'b0;
    in_valid6 = 1'b0;
    while (busy6 && t < 50) begin
      step();
      t++;
    end
    step();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++; $display("FAIL err_no_v: out_valid %b, required 0", out_valid6);
    end
    in_valid6 = 1'b1;
    in_idx = 3'd2;
    step();
    in_valid6 = 1'b0;
    vectors++;
    if (err6 !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky: got %b, required 1", err6);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    cfg(8'd100);
    charge(3'd0);
    charge(3'd1);
    out_ready = 1'b0;
    tick();
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL pre_rst_valid: got %b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_busy: got %b, required 0", busy);
    end
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_ready: got %b, required 0", in_ready);
    end
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      mrc[i] = 0;
    end
    mthr = 64;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = pops;
    send(3'd2, 4'd7, 11);
    tick();
    finish_sweep();
    vectors++;
    if (pops - base != 1) begin
      miscompares++; $display("FAIL post_rst: got %0d spikes, required 1", pops - base);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      mrc[i] = 0;
    end
    test_reset();
    test_tick_timing();
    test_integrate();
    test_clamp();
    test_full_fifo();
    test_ena();
    test_respike();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_lif_array.md
Name: neuron_lif_array

Overview:
- Parametrised multi-neuron successor of the single-neuron LIF core.
- Holds N_NEURONS leaky integrate-and-fire membranes, each targeted by address-routed weighted input events.
- A tick event triggers a sequential leak/threshold sweep across all neurons. Spikes are queued in an output FIFO as neuron indices for the IO front-end.

Parameters:
- N_NEURONS, 8, number of neurons; IDX_W = max(1, clog2(N_NEURONS)) is derived locally
- V_W, 8, membrane width; unsigned, range 0..2^V_W-1
- WGT_W, 4, signed event weight width
- LEAK_SHIFT, 3, per-tick leak is V - (V >> LEAK_SHIFT)
- THRESH_INIT, 64, reset value of the threshold register
- FIFO_DEPTH, 4, output spike FIFO entries; power of 2, at least 2
- REFRAC_TICKS, 2, refractory length in ticks; used only with the optional feature

Ports:
- clk input 1 clock
- rst_n input 1 asynchronous active-low reset
- ena input 1 global enable; when low, all state is frozen
- in_valid input 1 input event valid
- in_ready output 1 input event accepted when in_valid && in_ready
- in_tick input 1 event is a tick; in_idx and in_weight are ignored
- in_idx input IDX_W target neuron
- in_weight input WGT_W signed weight
- cfg_we input 1 threshold write strobe
- cfg_thresh input V_W new threshold
- out_valid output 1 FIFO non-empty
- out_ready input 1 consumer ready
- out_idx output IDX_W index of the spiking neuron at the FIFO head
- busy output 1 sweep in progress
- err output 1 sticky flag: out-of-range in_idx was accepted

Behaviour:
- Reset (rst_n, asynchronous, active-low; clock clk): all V = 0, thresh = THRESH_INIT, FIFO empty, state IDLE, err = 0.
  - Outputs at reset: out_valid = 0, out_idx = 0, busy = 0, in_ready = 0 while rst_n is low.
- State machine: IDLE and SWEEP.
  - in_ready = ena && state == IDLE.
  - busy = (state == SWEEP).
- Non-tick event accepted in IDLE:
  - V[in_idx] <= clamp(V + sign_extend(in_weight), 0, 2^V_W-1) at the same clock edge (one-cycle latency).
  - Addition uses V_W+2 bits before clamping.
- in_idx >= N_NEURONS: the event is consumed, no V changes, err <= 1. err clears only on reset.
- Tick accepted in IDLE at cycle k:
  - State goes to SWEEP with ptr = 0.
  - Neuron i is evaluated at cycle k+1+i when no stall occurs.
  - Evaluation: Vl = V - (V >> LEAK_SHIFT).
    - If Vl >= thresh: push i into the FIFO and set V <= 0.
    - Otherwise V <= Vl.
  - After ptr = N_NEURONS-1 is evaluated, state returns to IDLE; in_ready is high at cycle k+1+N_NEURONS.
- FIFO full while the current neuron needs to spike: stall.
  - ptr and V are unchanged and the neuron is retried each cycle.
  - A non-spiking neuron never stalls.
- Pop occurs when out_valid && out_ready && ena.
  - A push and a pop in the same cycle are both performed; a push into a full FIFO is legal only when a pop occurs in that cycle.
  - out_idx is the registered head entry; a spike appears on out_valid one cycle after its evaluation cycle.
  - Spike order is ascending index within a tick.
- cfg_we takes effect at the next edge in any state. During a sweep, later neurons use the new threshold and already-swept neurons are not re-evaluated.
- ena low: no V, ptr, FIFO, or threshold updates; out_valid and out_idx hold.
- Asynchronous reset mid-sweep aborts the sweep and clears all state.

Optional Feature:
- Macro: NEURON_LIF_ARRAY_REFRAC_EN.
- When defined:
  - Each neuron has a refractory counter that loads REFRAC_TICKS on spike.
  - While the counter is non-zero, input events to that neuron are consumed and ignored.
  - At the neuron's sweep slot the counter decrements, with no leak and no spike check.
- When undefined: no counters, and a neuron integrates immediately after it spikes.

Test Plan:
- Ten +7 events to neuron 3, then a tick → V3 = 70, leak to 62, no spike. Two more +7 events, then a tick → 76 leaks to 67 ≥ 64, out_idx = 3, V3 = 0.
- Forty +7 events to neuron 0 → V0 = 255 (clamped). Then with V1 = 3, one -8 event → V1 = 0, no wrap.
- All 8 neurons at 200, out_ready = 0, tick → 4 entries queued, busy = 1 and in_ready = 0 held. Raise out_ready → indices 0..7 in order, then busy falls.
- Event to in_idx = 9 with N_NEURONS = 16 → hmm invalid case; instead use N_NEURONS = 6 and in_idx = 7 → err = 1, no V change, in_ready stays high.
- Assert rst_n low at the third cycle of a sweep → immediately out_valid = 0 and busy = 0. After release, thresh = 64 and all V = 0.
- With NEURON_LIF_ARRAY_REFRAC_EN: neuron 2 spikes, the next two ticks ignore +7 inputs, and the third tick integrates normally.
